// File: rtl/svm_pkg.sv
// Shared constants, state encoding and SRAM word layout for the SVM model loader.
package svm_pkg;

  localparam int NBITS      = 9;
  localparam int VSUP_WIDTH = 120;
  localparam int ASUP_WIDTH = 155;
  localparam int F_WIDTH    = 214;
  localparam int ADDR_W     = 8;

  localparam int SUP_MAX = (VSUP_WIDTH > ASUP_WIDTH) ? VSUP_WIDTH : ASUP_WIDTH;
  localparam int ICPT_W  = 2 * NBITS + $clog2(SUP_MAX);
  localparam int WDATA_W = NBITS * (VSUP_WIDTH + ASUP_WIDTH + 2);

  // SRAM word layout, LSB first: v_support, a_support, v_alpha, a_alpha
  localparam int V_SUP_LSB   = 0;
  localparam int A_SUP_LSB   = V_SUP_LSB + NBITS * VSUP_WIDTH;
  localparam int V_ALPHA_LSB = A_SUP_LSB + NBITS * ASUP_WIDTH;
  localparam int A_ALPHA_LSB = V_ALPHA_LSB + NBITS;

  typedef enum logic [1:0] {
    RST_WAIT  = 2'd0,
    WAIT_ICPT = 2'd1,
    LOAD      = 2'd2,
    COMPLETE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/svm_model_loader_if.sv
// Host-to-loader model-load bus: intercept pair, per-row support/alpha writes, handshake.
interface svm_model_loader_if #(
  parameter int NBITS      = svm_pkg::NBITS,
  parameter int VSUP_WIDTH = svm_pkg::VSUP_WIDTH,
  parameter int ASUP_WIDTH = svm_pkg::ASUP_WIDTH,
  parameter int ADDR_W     = svm_pkg::ADDR_W,
  parameter int ICPT_W     = svm_pkg::ICPT_W
);
  logic [NBITS*VSUP_WIDTH-1:0] v_in_support;
  logic [NBITS*ASUP_WIDTH-1:0] a_in_support;
  logic [NBITS-1:0]            v_in_alpha;
  logic [NBITS-1:0]            a_in_alpha;
  logic [ICPT_W-1:0]           v_in_intercept;
  logic [ICPT_W-1:0]           a_in_intercept;
  logic [ADDR_W-1:0]           mem_write_addr;
  logic                        mem_we;
  logic                        mem_write_ready;
  logic                        mem_write_done;
  logic                        intercept_valid;

  modport master (
    output v_in_support, a_in_support, v_in_alpha, a_in_alpha,
    output v_in_intercept, a_in_intercept, mem_write_addr, mem_we,
    output mem_write_done, intercept_valid,
    input  mem_write_ready
  );

  modport slave (
    input  v_in_support, a_in_support, v_in_alpha, a_in_alpha,
    input  v_in_intercept, a_in_intercept, mem_write_addr, mem_we,
    input  mem_write_done, intercept_valid,
    output mem_write_ready
  );
endinterface

// File: rtl/svm_sram_wr_stage.sv
// Registered SRAM write stage: one-cycle sram_we pulse per accepted write with packed row data.
module svm_sram_wr_stage #(
  parameter int NBITS      = svm_pkg::NBITS,
  parameter int VSUP_WIDTH = svm_pkg::VSUP_WIDTH,
  parameter int ASUP_WIDTH = svm_pkg::ASUP_WIDTH,
  parameter int ADDR_W     = svm_pkg::ADDR_W
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr_i,
  input  logic [ADDR_W-1:0]                       addr_i,
  input  logic [NBITS*VSUP_WIDTH-1:0]             v_sup_i,
  input  logic [NBITS*ASUP_WIDTH-1:0]             a_sup_i,
  input  logic [NBITS-1:0]                        v_alpha_i,
  input  logic [NBITS-1:0]                        a_alpha_i,
  output logic                                    sram_we_o,
  output logic [ADDR_W-1:0]                       sram_addr_o,
  output logic [NBITS*(VSUP_WIDTH+ASUP_WIDTH+2)-1:0] sram_wdata_o
);
  logic                                          we_q;
  logic [ADDR_W-1:0]                             addr_q;
  logic [NBITS*(VSUP_WIDTH+ASUP_WIDTH+2)-1:0]    wdata_q;

  // Address/data hold their last value between writes; only the strobe pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= wr_i;
      if (wr_i) begin
        addr_q  <= addr_i;
        wdata_q <= {a_alpha_i, v_alpha_i, a_sup_i, v_sup_i};
      end else begin
        addr_q  <= addr_q;
        wdata_q <= wdata_q;
      end
    end
  end

  assign sram_we_o    = we_q;
  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = wdata_q;
endmodule

// File: rtl/svm_model_loader.sv
// Target side of the SVM model-load bus: intercept capture, row write forwarding to SRAM,
// write counting and model_valid/load_error qualification.
module svm_model_loader
  import svm_pkg::*;
#(
  parameter int NBITS      = svm_pkg::NBITS,
  parameter int VSUP_WIDTH = svm_pkg::VSUP_WIDTH,
  parameter int ASUP_WIDTH = svm_pkg::ASUP_WIDTH,
  parameter int F_WIDTH    = svm_pkg::F_WIDTH,
  parameter int ADDR_W     = svm_pkg::ADDR_W,
  parameter int ICPT_W     = svm_pkg::ICPT_W
) (
  input  logic                                       clk,
  input  logic                                       rst,
  svm_model_loader_if.slave                          ld,
  input  logic                                       reload_i,
  input  logic                                       engine_busy_i,
  output logic                                       sram_we_o,
  output logic [ADDR_W-1:0]                          sram_addr_o,
  output logic [NBITS*(VSUP_WIDTH+ASUP_WIDTH+2)-1:0] sram_wdata_o,
  output logic [ICPT_W-1:0]                          v_intercept_o,
  output logic [ICPT_W-1:0]                          a_intercept_o,
  output logic                                       model_valid_o,
  output logic                                       load_error_o
);
  localparam logic [ADDR_W:0] F_LIMIT = (ADDR_W+1)'(F_WIDTH);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic              err_q, err_d, valid_q, valid_d, ready_q, ready_d, pend_q, pend_d;
  logic [ICPT_W-1:0] v_icpt_q, v_icpt_d, a_icpt_q, a_icpt_d;
  logic              wr_req_s, addr_ok_s, accept_s;

  assign wr_req_s  = ~ld.mem_we;
  assign addr_ok_s = ({1'b0, ld.mem_write_addr} < F_LIMIT);
  assign accept_s  = (state_q == LOAD) && wr_req_s && addr_ok_s;
  // Saturating count so an over-long load can never wrap back to F_WIDTH
  assign cnt_inc_s = (accept_s && (cnt_q != {ADDR_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    valid_d  = valid_q;
    pend_d   = pend_q;
    v_icpt_d = v_icpt_q;
    a_icpt_d = a_icpt_q;
    case (state_q)
      RST_WAIT: state_d = WAIT_ICPT;
      WAIT_ICPT: begin
        if (wr_req_s) err_d = 1'b1;
        else          err_d = err_q;
        if (ld.intercept_valid) begin
          v_icpt_d = ld.v_in_intercept;
          a_icpt_d = ld.a_in_intercept;
          state_d  = LOAD;
        end else begin
          state_d  = WAIT_ICPT;
        end
      end
      LOAD: begin
        cnt_d = cnt_inc_s;
        if (wr_req_s && !addr_ok_s) err_d = 1'b1;
        else                        err_d = err_q;
        if (ld.intercept_valid) begin
          v_icpt_d = ld.v_in_intercept;
          a_icpt_d = ld.a_in_intercept;
        end else begin
          v_icpt_d = v_icpt_q;
        end
        // The write accompanying mem_write_done is already folded into cnt_inc_s
        if (ld.mem_write_done) begin
          state_d = COMPLETE;
          if (({1'b0, cnt_inc_s} == F_LIMIT) && !err_d) begin
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
            err_d   = 1'b1;
          end
        end else begin
          state_d = LOAD;
        end
      end
      COMPLETE: begin
        if ((reload_i || pend_q) && !engine_busy_i) begin
          state_d = WAIT_ICPT;
          cnt_d   = '0;
          err_d   = 1'b0;
          valid_d = 1'b0;
          pend_d  = 1'b0;
        end else if (reload_i) begin
          pend_d  = 1'b1;
        end else begin
          pend_d  = pend_q;
        end
      end
      default: state_d = RST_WAIT;
    endcase
    ready_d = (state_d == WAIT_ICPT) || (state_d == LOAD);
  end

  // Control and intercept registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RST_WAIT;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      pend_q   <= 1'b0;
      v_icpt_q <= '0;
      a_icpt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      pend_q   <= pend_d;
      v_icpt_q <= v_icpt_d;
      a_icpt_q <= a_icpt_d;
    end
  end

  svm_sram_wr_stage #(
    .NBITS(NBITS), .VSUP_WIDTH(VSUP_WIDTH), .ASUP_WIDTH(ASUP_WIDTH), .ADDR_W(ADDR_W)
  ) u_wr_stage (
    .clk          (clk),
    .rst          (rst),
    .wr_i         (accept_s),
    .addr_i       (ld.mem_write_addr),
    .v_sup_i      (ld.v_in_support),
    .a_sup_i      (ld.a_in_support),
    .v_alpha_i    (ld.v_in_alpha),
    .a_alpha_i    (ld.a_in_alpha),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o)
  );

  assign ld.mem_write_ready = ready_q;
  assign v_intercept_o      = v_icpt_q;
  assign a_intercept_o      = a_icpt_q;
  assign model_valid_o      = valid_q;
  assign load_error_o       = err_q;
endmodule

// File: tb/tb_svm_model_loader.sv
// Directed self-checking bench for svm_model_loader.
module tb_svm_model_loader;
  import svm_pkg::*;

  localparam logic [ICPT_W-1:0] V_NOM  = ICPT_W'(-1234);
  localparam logic [ICPT_W-1:0] A_NOM  = ICPT_W'(5678);
  localparam logic [ICPT_W-1:0] V_LATE = ICPT_W'(-7);
  localparam logic [ICPT_W-1:0] A_LATE = ICPT_W'(99);

  logic clk = 1'b0;
  logic rst, reload, engine_busy;
  logic sram_we, model_valid, load_error;
  logic [ADDR_W-1:0]  sram_addr;
  logic [WDATA_W-1:0] sram_wdata;
  logic [ICPT_W-1:0]  v_intercept, a_intercept;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  svm_model_loader_if bus();

  svm_model_loader dut (
    .clk           (clk),
    .rst           (rst),
    .ld            (bus),
    .reload_i      (reload),
    .engine_busy_i (engine_busy),
    .sram_we_o     (sram_we),
    .sram_addr_o   (sram_addr),
    .sram_wdata_o  (sram_wdata),
    .v_intercept_o (v_intercept),
    .a_intercept_o (a_intercept),
    .model_valid_o (model_valid),
    .load_error_o  (load_error)
  );

  function automatic logic [NBITS-1:0] vs_of(input int i); return NBITS'(i); endfunction
  function automatic logic [NBITS-1:0] as_of(input int i); return NBITS'(i) ^ 9'h155; endfunction
  function automatic logic [NBITS-1:0] va_of(input int i); return NBITS'(i * 3); endfunction
  function automatic logic [NBITS-1:0] aa_of(input int i); return NBITS'(511 - i); endfunction

  function automatic logic [WDATA_W-1:0] row_word(input int i);
    logic [WDATA_W-1:0] w;
    w = '0;
    for (int k = 0; k < VSUP_WIDTH; k++) w[V_SUP_LSB + k*NBITS +: NBITS] = vs_of(i);
    for (int k = 0; k < ASUP_WIDTH; k++) w[A_SUP_LSB + k*NBITS +: NBITS] = as_of(i);
    w[V_ALPHA_LSB +: NBITS] = va_of(i);
    w[A_ALPHA_LSB +: NBITS] = aa_of(i);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_word(input string tag, input logic [WDATA_W-1:0] obs, input logic [WDATA_W-1:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed top %0h low %0h expected top %0h low %0h", tag,
                obs[WDATA_W-1 -: 32], obs[31:0], exp[WDATA_W-1 -: 32], exp[31:0]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_row(input int i);
    for (int k = 0; k < VSUP_WIDTH; k++) bus.v_in_support[k*NBITS +: NBITS] = vs_of(i);
    for (int k = 0; k < ASUP_WIDTH; k++) bus.a_in_support[k*NBITS +: NBITS] = as_of(i);
    bus.v_in_alpha     = va_of(i);
    bus.a_in_alpha     = aa_of(i);
    bus.mem_write_addr = ADDR_W'(i);
    bus.mem_we         = 1'b0;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 10 && bus.mem_write_ready !== 1'b1; k++) tick();
    chk("ready_wait", 64'(bus.mem_write_ready), 64'd1);
  endtask

  task automatic do_reload();
    reload = 1'b1; engine_busy = 1'b0;
    tick();
    reload = 1'b0;
    chk("reload_ready", 64'(bus.mem_write_ready), 64'd1);
    chk("reload_valid", 64'(model_valid), 64'd0);
    chk("reload_err", 64'(load_error), 64'd0);
  endtask

  task automatic run_load(input int nrows, input bit done_same, input bit bad, input bit late,
                          input bit exp_valid);
    int pulses = 0;
    bus.v_in_intercept = V_NOM; bus.a_in_intercept = A_NOM; bus.intercept_valid = 1'b1;
    tick();
    bus.intercept_valid = 1'b0;
    for (int i = 0; i < nrows; i++) begin
      if (bad && i == 50) begin
        bus.mem_write_addr = ADDR_W'(F_WIDTH); bus.mem_we = 1'b0;
        tick();
        chk("bad_addr_no_we", 64'(sram_we), 64'd0);
      end
      if (late && i == 10) begin
        bus.v_in_intercept = V_LATE; bus.a_in_intercept = A_LATE; bus.intercept_valid = 1'b1;
      end
      drive_row(i);
      if (done_same && i == nrows - 1) bus.mem_write_done = 1'b1;
      tick();
      bus.intercept_valid = 1'b0;
      if (sram_we === 1'b1) pulses++;
      chk("sram_we", 64'(sram_we), 64'd1);
      chk("sram_addr", 64'(sram_addr), 64'(i));
      if (i == 0 || i == 77 || i == nrows - 1) chk_word("sram_wdata", sram_wdata, row_word(i));
    end
    bus.mem_we = 1'b1;
    if (!done_same) begin
      bus.mem_write_done = 1'b1;
      tick();
      chk("we_after_last", 64'(sram_we), 64'd0);
    end
    bus.mem_write_done = 1'b0;
    chk("pulse_count", 64'(pulses), 64'(nrows));
    chk("ready_complete", 64'(bus.mem_write_ready), 64'd0);
    chk("model_valid", 64'(model_valid), 64'(exp_valid));
    chk("load_error", 64'(load_error), 64'(!exp_valid));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sram_we"}, 64'(sram_we), 64'd0);
    chk({tag, "_sram_addr"}, 64'(sram_addr), 64'd0);
    chk_word({tag, "_sram_wdata"}, sram_wdata, '0);
    chk({tag, "_v_icpt"}, 64'(v_intercept), 64'd0);
    chk({tag, "_a_icpt"}, 64'(a_intercept), 64'd0);
    chk({tag, "_valid"}, 64'(model_valid), 64'd0);
    chk({tag, "_err"}, 64'(load_error), 64'd0);
    chk({tag, "_ready"}, 64'(bus.mem_write_ready), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; reload = 1'b0; engine_busy = 1'b0;
    bus.v_in_support = '0; bus.a_in_support = '0; bus.v_in_alpha = '0; bus.a_in_alpha = '0;
    bus.v_in_intercept = '0; bus.a_in_intercept = '0; bus.mem_write_addr = '0;
    bus.mem_we = 1'b1; bus.mem_write_done = 1'b0; bus.intercept_valid = 1'b0;
    #2;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wait_ready", 64'(bus.mem_write_ready), 64'd0);
    tick();
    chk("ready_after_1cyc", 64'(bus.mem_write_ready), 64'd1);

    // Nominal load
    run_load(F_WIDTH, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("nom_v_icpt", 64'(v_intercept), 64'(V_NOM));
    chk("nom_a_icpt", 64'(a_intercept), 64'(A_NOM));

    // Reload held off while the engine is busy
    reload = 1'b1; engine_busy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("busy_valid_held", 64'(model_valid), 64'd1);
      chk("busy_ready_low", 64'(bus.mem_write_ready), 64'd0);
    end
    reload = 1'b0; engine_busy = 1'b0;
    tick();
    chk("pend_valid_clr", 64'(model_valid), 64'd0);
    chk("pend_ready", 64'(bus.mem_write_ready), 64'd1);
    chk("pend_err", 64'(load_error), 64'd0);

    // Short load
    run_load(F_WIDTH - 1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reload();

    // Out-of-range address among a full set of valid writes
    run_load(F_WIDTH, 1'b0, 1'b1, 1'b0, 1'b0);
    do_reload();

    // Write before intercept is ignored and flags the load
    drive_row(5);
    tick();
    bus.mem_we = 1'b1;
    chk("early_wr_no_we", 64'(sram_we), 64'd0);
    chk("early_wr_ready", 64'(bus.mem_write_ready), 64'd1);
    run_load(F_WIDTH, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reload();

    // Last write coincident with done, plus a late intercept re-latch
    run_load(F_WIDTH, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("late_v_icpt", 64'(v_intercept), 64'(V_LATE));
    chk("late_a_icpt", 64'(a_intercept), 64'(A_LATE));
    do_reload();

    // mem_write_done outside LOAD is ignored
    bus.mem_write_done = 1'b1;
    tick();
    bus.mem_write_done = 1'b0;
    chk("done_ignored_ready", 64'(bus.mem_write_ready), 64'd1);
    chk("done_ignored_valid", 64'(model_valid), 64'd0);

    // Reset in the middle of a load
    bus.v_in_intercept = V_NOM; bus.a_in_intercept = A_NOM; bus.intercept_valid = 1'b1;
    tick();
    bus.intercept_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drive_row(i);
      tick();
    end
    chk("pre_rst_we", 64'(sram_we), 64'd1);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    bus.mem_we = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready();
    run_load(F_WIDTH, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
